// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU port, the DMA port and the data-memory bus of the
// data-memory arbiter so they travel as one port between modules.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    // CPU (MEM stage) port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wd;
    logic [DATA_W-1:0] cpu_rd;
    logic              cpu_stall;

    // DMA (image engine) port
    logic              dma_valid;
    logic              dma_ready;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wd;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    // Single-port data memory
    logic              mem_we;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    // Status
    logic              oob_err;
    logic              oob_sticky;
    logic [CNT_W-1:0]  stall_count;

    // Requesters and memory side: drives requests and read data, observes results
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        output dma_valid, dma_we, dma_addr, dma_wd,
        output mem_rd,
        input  cpu_rd, cpu_stall,
        input  dma_ready, dma_rvalid, dma_rdata,
        input  mem_we, mem_address, mem_wd,
        input  oob_err, oob_sticky, stall_count
    );

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  dma_valid, dma_we, dma_addr, dma_wd,
        input  mem_rd,
        output cpu_rd, cpu_stall,
        output dma_ready, dma_rvalid, dma_rdata,
        output mem_we, mem_address, mem_wd,
        output oob_err, oob_sticky, stall_count
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU MEM stage has fixed priority over the image
// DMA engine, but a bounded-wait counter forces a DMA slot after MAX_WAIT
// consecutive denials. Out-of-range accesses never write memory and are
// reported through oob_err / oob_sticky.
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 129600,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);

    localparam int                WAIT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] DEPTH_C    = ADDR_W'(DEPTH);

    logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic              dma_rvalid_q,  dma_rvalid_d;
    logic [DATA_W-1:0] dma_rdata_q,   dma_rdata_d;
    logic              oob_err_q,     oob_err_d;
    logic              oob_sticky_q,  oob_sticky_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic              force_dma;
    logic              grant_dma;
    logic              grant_cpu;
    logic              any_grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wd;
    logic              in_range;

    // Pick the winner and route its request onto the memory bus; everything is gated off in reset
    always_comb begin
        force_dma = 1'b0;
        grant_dma = 1'b0;
        grant_cpu = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wd    = '0;
        if (rst_n) begin
            force_dma = bus.dma_valid && (wait_cnt_q == MAX_WAIT_C);
            grant_dma = bus.dma_valid && (!bus.cpu_req || force_dma);
            grant_cpu = bus.cpu_req && !grant_dma;
        end
        if (grant_dma) begin
            sel_we   = bus.dma_we;
            sel_addr = bus.dma_addr;
            sel_wd   = bus.dma_wd;
        end else if (grant_cpu) begin
            sel_we   = bus.cpu_we;
            sel_addr = bus.cpu_addr;
            sel_wd   = bus.cpu_wd;
        end
        any_grant = grant_dma || grant_cpu;
        in_range  = (sel_addr < DEPTH_C);
    end

    assign bus.mem_we      = any_grant && sel_we && in_range;
    assign bus.mem_address = sel_addr;
    assign bus.mem_wd      = sel_wd;
    assign bus.cpu_rd      = (grant_cpu && in_range) ? bus.mem_rd : '0;
    assign bus.cpu_stall   = bus.cpu_req && grant_dma;
    assign bus.dma_ready   = grant_dma;

    assign bus.dma_rvalid  = dma_rvalid_q;
    assign bus.dma_rdata   = dma_rdata_q;
    assign bus.oob_err     = oob_err_q;
    assign bus.oob_sticky  = oob_sticky_q;
    assign bus.stall_count = stall_count_q;

    // Count consecutive cycles the DMA was left waiting, capped at MAX_WAIT
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.dma_valid || grant_dma) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Capture DMA read data one cycle after grant; out-of-range reads return zero
    always_comb begin
        dma_rvalid_d = grant_dma && !bus.dma_we;
        dma_rdata_d  = dma_rdata_q;
        if (dma_rvalid_d) begin
            dma_rdata_d = in_range ? bus.mem_rd : '0;
        end
    end

    // Flag granted out-of-range accesses and count stalled CPU cycles without wrapping
    always_comb begin
        oob_err_d     = any_grant && !in_range;
        oob_sticky_d  = oob_sticky_q || oob_err_d;
        stall_count_d = stall_count_q;
        if (bus.cpu_stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // State registers; reset drops any pending read response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            dma_rvalid_q  <= 1'b0;
            dma_rdata_q   <= '0;
            oob_err_q     <= 1'b0;
            oob_sticky_q  <= 1'b0;
            stall_count_q <= '0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            dma_rvalid_q  <= dma_rvalid_d;
            dma_rdata_q   <= dma_rdata_d;
            oob_err_q     <= oob_err_d;
            oob_sticky_q  <= oob_sticky_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory attached.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mem [0:1023];

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(16)) bus ();

    dmem_arbiter #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(129600), .MAX_WAIT(4), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge
    assign bus.mem_rd = mem[bus.mem_address[9:0]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_address[9:0]] <= bus.mem_wd;
    end

    // Drive one cycle's inputs after the falling edge and settle before checking
    task automatic applyStimulus(input logic creq, input logic cwe,
                                 input logic [31:0] caddr, input logic [31:0] cwd,
                                 input logic dval, input logic dwe,
                                 input logic [31:0] daddr, input logic [31:0] dwd);
        @(negedge clk);
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wd    = cwd;
        bus.dma_valid = dval;
        bus.dma_we    = dwe;
        bus.dma_addr  = daddr;
        bus.dma_wd    = dwd;
        #1;
    endtask

    // One comparison
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[5] = 32'h1234;

        // Reset held with requests asserted
        rst_n         = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'd100;
        bus.cpu_wd    = 32'h77;
        bus.dma_valid = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 32'd6;
        bus.dma_wd    = 32'h88;
        #1;
        checkOutput("rst_mem_we", bus.mem_we, 0);
        checkOutput("rst_dma_ready", bus.dma_ready, 0);
        checkOutput("rst_cpu_stall", bus.cpu_stall, 0);
        checkOutput("rst_mem_address", bus.mem_address, 0);
        checkOutput("rst_mem_wd", bus.mem_wd, 0);
        checkOutput("rst_cpu_rd", bus.cpu_rd, 0);
        applyStimulus(1, 1, 100, 32'h77, 1, 1, 6, 32'h88);
        applyStimulus(1, 1, 100, 32'h77, 1, 1, 6, 32'h88);
        checkOutput("rst_mem_we_clk", bus.mem_we, 0);
        checkOutput("rst_rvalid", bus.dma_rvalid, 0);
        checkOutput("rst_rdata", bus.dma_rdata, 0);
        checkOutput("rst_oob_err", bus.oob_err, 0);
        checkOutput("rst_oob_sticky", bus.oob_sticky, 0);
        checkOutput("rst_stall_count", bus.stall_count, 0);
        checkOutput("rst_mem6_untouched", mem[6], 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // CPU store then load at 100
        applyStimulus(1, 1, 100, 32'hDEAD, 0, 0, 0, 0);
        checkOutput("cpu_st_mem_we", bus.mem_we, 1);
        checkOutput("cpu_st_addr", bus.mem_address, 100);
        checkOutput("cpu_st_wd", bus.mem_wd, 32'hDEAD);
        checkOutput("cpu_st_stall", bus.cpu_stall, 0);
        applyStimulus(1, 0, 100, 0, 0, 0, 0, 0);
        checkOutput("cpu_ld_rd", bus.cpu_rd, 32'hDEAD);
        checkOutput("cpu_ld_mem_we", bus.mem_we, 0);
        checkOutput("cpu_ld_stall", bus.cpu_stall, 0);

        // DMA read at 5, then DMA write at 6
        applyStimulus(0, 0, 0, 0, 1, 0, 5, 0);
        checkOutput("dma_rd_ready", bus.dma_ready, 1);
        checkOutput("dma_rd_addr", bus.mem_address, 5);
        checkOutput("dma_rd_rvalid0", bus.dma_rvalid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("dma_rd_rvalid1", bus.dma_rvalid, 1);
        checkOutput("dma_rd_rdata", bus.dma_rdata, 32'h1234);
        applyStimulus(0, 0, 0, 0, 1, 1, 6, 32'hCAFE);
        checkOutput("dma_wr_ready", bus.dma_ready, 1);
        checkOutput("dma_wr_mem_we", bus.mem_we, 1);
        checkOutput("dma_wr_wd", bus.mem_wd, 32'hCAFE);
        checkOutput("dma_wr_rvalid", bus.dma_rvalid, 0);
        checkOutput("dma_rdata_hold", bus.dma_rdata, 32'h1234);
        applyStimulus(1, 0, 6, 0, 0, 0, 0, 0);
        checkOutput("cpu_ld6", bus.cpu_rd, 32'hCAFE);

        // Same-address writes: CPU wins, DMA lands next cycle
        applyStimulus(1, 1, 7, 32'hA1, 1, 1, 7, 32'hB2);
        checkOutput("same_wd", bus.mem_wd, 32'hA1);
        checkOutput("same_dma_ready", bus.dma_ready, 0);
        checkOutput("same_mem_we", bus.mem_we, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 7, 32'hB2);
        checkOutput("same_dma_ready2", bus.dma_ready, 1);
        checkOutput("same_wd2", bus.mem_wd, 32'hB2);
        applyStimulus(1, 0, 7, 0, 0, 0, 0, 0);
        checkOutput("same_ld7", bus.cpu_rd, 32'hB2);

        // Contention: DMA forced every fifth cycle
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1, 0, 100, 0, 1, 0, 5, 0);
            checkOutput($sformatf("cont_ready_%0d", c), bus.dma_ready, (c % 5 == 4) ? 1 : 0);
            checkOutput($sformatf("cont_stall_%0d", c), bus.cpu_stall, (c % 5 == 4) ? 1 : 0);
            checkOutput($sformatf("cont_cpu_rd_%0d", c), bus.cpu_rd, (c % 5 == 4) ? 32'h0 : 32'hDEAD);
            checkOutput($sformatf("cont_cnt_%0d", c), bus.stall_count, c / 5);
            checkOutput($sformatf("cont_rvalid_%0d", c), bus.dma_rvalid, (c % 5 == 0 && c > 0) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("cont_cnt_end", bus.stall_count, 2);
        checkOutput("cont_rvalid_end", bus.dma_rvalid, 1);
        checkOutput("cont_rdata_end", bus.dma_rdata, 32'h1234);

        // Out-of-range accesses, including the last legal address
        applyStimulus(1, 1, 129600, 32'h55, 0, 0, 0, 0);
        checkOutput("oob_mem_we", bus.mem_we, 0);
        checkOutput("oob_addr", bus.mem_address, 129600);
        checkOutput("oob_err_before", bus.oob_err, 0);
        checkOutput("oob_sticky_before", bus.oob_sticky, 0);
        applyStimulus(1, 1, 129599, 32'h66, 0, 0, 0, 0);
        checkOutput("edge_mem_we", bus.mem_we, 1);
        checkOutput("oob_err_pulse", bus.oob_err, 1);
        checkOutput("oob_sticky_set", bus.oob_sticky, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("oob_err_cleared", bus.oob_err, 0);
        checkOutput("oob_sticky_held", bus.oob_sticky, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 200000, 0);
        checkOutput("oob_dma_ready", bus.dma_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("oob_dma_rvalid", bus.dma_rvalid, 1);
        checkOutput("oob_dma_rdata", bus.dma_rdata, 0);
        checkOutput("oob_dma_err", bus.oob_err, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("oob_dma_err_clr", bus.oob_err, 0);
        checkOutput("oob_sticky_final", bus.oob_sticky, 1);

        // Reset asserted between a DMA read grant and its response edge
        applyStimulus(0, 0, 0, 0, 1, 0, 5, 0);
        checkOutput("mid_ready", bus.dma_ready, 1);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_rvalid", bus.dma_rvalid, 0);
        checkOutput("mid_sticky", bus.oob_sticky, 0);
        checkOutput("mid_stall_count", bus.stall_count, 0);
        checkOutput("mid_ready_gated", bus.dma_ready, 0);
        applyStimulus(1, 0, 100, 0, 1, 0, 5, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rvalid", bus.dma_rvalid, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) applyStimulus(1, 0, 100, 0, 1, 0, 5, 0);
            checkOutput($sformatf("post_ready_%0d", k), bus.dma_ready, (k == 4) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
